// File: rtl/slave_fifo2b_stream_in_if.sv
`timescale 1ns/1ps
// FPGA-side source and FX3 slave-FIFO bus signals for the stream-IN writer.
// The slave modport is the writer's view; the master modport drives it.
interface slave_fifo2b_stream_in_if #(
  parameter int unsigned DATA_W = 32
);
  logic              stream_in_mode_selected;
  logic              flaga_d;
  logic              flagb_d;
  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic              src_last;
  logic              src_ready;
  logic              slwr_streamIN_;
  logic              pktend_streamIN_;
  logic [DATA_W-1:0] data_out;
  logic              streaming;
  logic [15:0]       words_written;

  modport slave (
    input  stream_in_mode_selected,
    input  flaga_d,
    input  flagb_d,
    input  src_data,
    input  src_valid,
    input  src_last,
    output src_ready,
    output slwr_streamIN_,
    output pktend_streamIN_,
    output data_out,
    output streaming,
    output words_written
  );

  modport master (
    output stream_in_mode_selected,
    output flaga_d,
    output flagb_d,
    output src_data,
    output src_valid,
    output src_last,
    input  src_ready,
    input  slwr_streamIN_,
    input  pktend_streamIN_,
    input  data_out,
    input  streaming,
    input  words_written
  );
endinterface

// File: rtl/slave_fifo2b_stream_in.sv
`timescale 1ns/1ps
// FX3 slave-FIFO stream-IN writer: elastic buffer of {data,last} words drained
// onto the bus by a flag-qualified write FSM.
module slave_fifo2b_stream_in #(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned WR_DELAY_CYCLES = 3
) (
  input  logic                     clk_100,
  input  logic                     reset,
  slave_fifo2b_stream_in_if.slave  bus
);

  localparam int unsigned ADDR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WCNT_W = 16;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_FLAGA_RCVD = 3'd1;
  localparam logic [2:0] S_WAIT_FLAGB = 3'd2;
  localparam logic [2:0] S_WRITE      = 3'd3;
  localparam logic [2:0] S_WR_DELAY   = 3'd4;

  logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last_q;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  dly_q, dly_d;
  logic [WCNT_W-1:0] words_q, words_d;

  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head_data;
  logic              head_last;

  // Extra pointer bit distinguishes full from empty when addresses match.
  assign wr_addr   = wr_ptr_q[ADDR_W-1:0];
  assign rd_addr   = rd_ptr_q[ADDR_W-1:0];
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) && (wr_addr == rd_addr);
  assign head_data = mem_data_q[rd_addr];
  assign head_last = mem_last_q[rd_addr];

  assign bus.src_ready = bus.stream_in_mode_selected & ~full;
  assign push          = bus.src_valid & bus.src_ready;
  assign pop           = (state_q == S_WRITE) & ~empty;

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge clk_100) begin
    if (push) begin
      mem_data_q[wr_addr] <= bus.src_data;
      mem_last_q[wr_addr] <= bus.src_last;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    words_d  = words_q + WCNT_W'(pop);
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    case (state_q)
      S_IDLE: begin
        if (bus.stream_in_mode_selected && bus.flaga_d) begin
          state_d = S_FLAGA_RCVD;
        end
      end
      S_FLAGA_RCVD: begin
        state_d = S_WAIT_FLAGB;
      end
      S_WAIT_FLAGB: begin
        if (!bus.stream_in_mode_selected) begin
          state_d = S_IDLE;
        end else if (bus.flagb_d) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // The write of this cycle still completes; only the next cycle idles.
        if (!bus.flagb_d || (pop && head_last) || !bus.stream_in_mode_selected) begin
          state_d = S_WR_DELAY;
          dly_d   = CNT_W'(WR_DELAY_CYCLES - 1);
        end
      end
      S_WR_DELAY: begin
        if (dly_q == '0) begin
          state_d = S_IDLE;
        end else begin
          dly_d = dly_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      dly_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      words_q  <= '0;
    end else begin
      state_q  <= state_d;
      dly_q    <= dly_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      words_q  <= words_d;
    end
  end

  // Bus outputs follow the registered state and buffer head directly.
  assign bus.slwr_streamIN_   = ~pop;
  assign bus.pktend_streamIN_ = ~(pop & head_last);
  assign bus.data_out         = pop ? head_data : '0;
  assign bus.streaming        = (state_q == S_WRITE);
  assign bus.words_written    = words_q;

endmodule
